// File: rtl/usb_rx_burst_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// usb_rx_burst_scheduler_pkg
//   Shared definitions for the FX2 host->FPGA read sequencer: default packet
//   geometry, the inter-burst gap length, the word index width and the
//   scheduler state codes.
// -----------------------------------------------------------------------------
package usb_rx_burst_scheduler_pkg;

  // 512-byte USB bulk packet carried as 16-bit words
  localparam int USB_PKT_WORDS  = 256;
  // downstream inband packet FIFO: 2**11 words deep
  localparam int USB_FIFO_AW    = 11;
  // idle cycles between bursts so the FX2 flags can settle
  localparam int USB_GAP_CYCLES = 2;
  // word index width; limits a burst to 256 words
  localparam int USB_IDX_W      = 8;
  // bursts-completed counter width
  localparam int USB_CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SPACE = 2'd1,
    ST_READ       = 2'd2,
    ST_GAP        = 2'd3
  } burst_state_e;

endpackage

// File: rtl/usb_burst_counter.sv
// -----------------------------------------------------------------------------
// usb_burst_counter
//   Loadable up-counter with a terminal-count compare. Counting stops at the
//   terminal value so the count never wraps past it.
// Ports
//   clk, rst_n  clock / asynchronous active-low reset
//   load        load load_val on the next edge (has priority over en)
//   load_val    value loaded when load=1
//   en          advance by one per cycle while below term
//   term        terminal value
//   count       registered count
//   tc          1 while en=1 and count==term
// -----------------------------------------------------------------------------
module usb_burst_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;
  logic         at_term;

  assign at_term = (count_q == term);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && !at_term) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = en && at_term;

endmodule

// File: rtl/usb_rx_burst_scheduler.sv
// -----------------------------------------------------------------------------
// usb_rx_burst_scheduler
//   Sequences FX2 slave-FIFO reads on the host->FPGA path. Each burst reads
//   exactly one packet of PKT_WORDS 16-bit words, and a burst is only started
//   when the FX2 has a packet ready and the downstream FIFO can take all of
//   it. Once started a burst always runs to completion.
// Ports
//   usbclk        sole clock, posedge
//   bus_reset_n   asynchronous active-low reset
//   enable        1 = bursts allowed; 0 = finish the current burst, then idle
//   have_pkt_rdy  FX2 packet-available flag (already in usbclk domain)
//   fifo_used     downstream FIFO fill level in words
//   RD            read strobe to the FX2
//   rdreq         write strobe to the packet FIFO, identical to RD
//   pkt_start     pulse on the first word of a burst
//   pkt_done      pulse on the last word of a burst
//   word_idx      index of the current word, valid while RD=1
//   pkt_count     bursts completed since reset, wraps
//   busy          1 whenever the scheduler is not idle
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for enable & packet ready & room for a whole packet
// WAIT_SPACE | packet ready but FIFO too full; waiting for room
// READ       | RD high, one word per cycle, PKT_WORDS cycles
// GAP        | RD low after a burst so the FX2 flags settle
// -----------------------------------------------------------------------------
module usb_rx_burst_scheduler
  import usb_rx_burst_scheduler_pkg::*;
#(
  parameter int PKT_WORDS  = USB_PKT_WORDS,
  parameter int FIFO_AW    = USB_FIFO_AW,
  parameter int GAP_CYCLES = USB_GAP_CYCLES
) (
  input  logic                 usbclk,
  input  logic                 bus_reset_n,
  input  logic                 enable,
  input  logic                 have_pkt_rdy,
  input  logic [FIFO_AW-1:0]   fifo_used,
  output logic                 RD,
  output logic                 rdreq,
  output logic                 pkt_start,
  output logic                 pkt_done,
  output logic [USB_IDX_W-1:0] word_idx,
  output logic [USB_CNT_W-1:0] pkt_count,
  output logic                 busy
);

  localparam logic [USB_IDX_W-1:0] LAST_WORD  = USB_IDX_W'(PKT_WORDS - 1);
  // The IDLE cycle that follows the GAP state is itself one of the quiet
  // cycles, so the GAP state lasts GAP_CYCLES-1 cycles.
  localparam bit                   HAS_GAP    = (GAP_CYCLES > 1);
  localparam logic [USB_IDX_W-1:0] GAP_LAST   = USB_IDX_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
  localparam logic [FIFO_AW:0]     FIFO_DEPTH = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]     PKT_EXT    = (FIFO_AW + 1)'(PKT_WORDS);

  burst_state_e state_d, state_q;

  logic                 rd_d, rd_q;
  logic                 pkt_start_d, pkt_start_q;
  logic                 pkt_done_d, pkt_done_q;
  logic                 busy_d, busy_q;
  logic [USB_CNT_W-1:0] pkt_count_d, pkt_count_q;

  logic [FIFO_AW:0]     fifo_room;
  logic                 space_ok;
  logic                 start_burst;
  logic                 enter_gap;

  logic                 cnt_load;
  logic                 cnt_en;
  logic [USB_IDX_W-1:0] cnt_term;
  logic [USB_IDX_W-1:0] cnt;
  logic                 cnt_tc;

  // Free space in one extra bit so an empty FIFO (room = depth) cannot wrap.
  assign fifo_room = FIFO_DEPTH - {1'b0, fifo_used};
  assign space_ok  = (fifo_room >= PKT_EXT);

  // One counter serves both READ (word index) and GAP (settle timer); the two
  // states never overlap, so only the terminal value changes with state.
  assign cnt_load = start_burst || enter_gap;
  assign cnt_en   = (state_q == ST_READ) || (state_q == ST_GAP);
  assign cnt_term = (state_q == ST_GAP) ? GAP_LAST : LAST_WORD;

  usb_burst_counter #(
    .W (USB_IDX_W)
  ) u_burst_counter (
    .clk      (usbclk),
    .rst_n    (bus_reset_n),
    .load     (cnt_load),
    .load_val ('0),
    .en       (cnt_en),
    .term     (cnt_term),
    .count    (cnt),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    start_burst = 1'b0;
    enter_gap   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && have_pkt_rdy && space_ok) begin
          state_d     = ST_READ;
          start_burst = 1'b1;
        end else if (have_pkt_rdy && !space_ok) begin
          state_d = ST_WAIT_SPACE;
        end
      end
      ST_WAIT_SPACE: begin
        if (!enable || !have_pkt_rdy) begin
          state_d = ST_IDLE;
        end else if (space_ok) begin
          state_d     = ST_READ;
          start_burst = 1'b1;
        end
      end
      // enable / flag / fill level are deliberately ignored here: the FX2
      // flag lags, and a packet must never be split.
      ST_READ: begin
        if (cnt_tc) begin
          if (HAS_GAP) begin
            state_d   = ST_GAP;
            enter_gap = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (cnt_tc) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // cycle the state register enters.
  always_comb begin
    rd_d        = (state_d == ST_READ);
    pkt_start_d = start_burst;
    if (start_burst) begin
      pkt_done_d = (LAST_WORD == '0);
    end else begin
      pkt_done_d = (state_q == ST_READ) && !cnt_tc &&
                   (USB_IDX_W'(cnt + USB_IDX_W'(1)) == LAST_WORD);
    end
    busy_d      = (state_d != ST_IDLE);
    pkt_count_d = pkt_count_q + USB_CNT_W'(pkt_done_d);
  end

  always_ff @(posedge usbclk or negedge bus_reset_n) begin
    if (!bus_reset_n) begin
      state_q     <= ST_IDLE;
      rd_q        <= 1'b0;
      pkt_start_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      pkt_start_q <= pkt_start_d;
      pkt_done_q  <= pkt_done_d;
      busy_q      <= busy_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign RD        = rd_q;
  assign rdreq     = rd_q;
  assign pkt_start = pkt_start_q;
  assign pkt_done  = pkt_done_q;
  assign word_idx  = cnt;
  assign pkt_count = pkt_count_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_usb_rx_burst_scheduler.sv
module tb_usb_rx_burst_scheduler;

  localparam int PKT   = 256;
  localparam int AW    = 11;
  localparam int GAP   = 2;
  localparam int DEPTH = 1 << AW;

  logic          usbclk = 1'b0;
  logic          bus_reset_n;
  logic          enable;
  logic          have_pkt_rdy;
  logic [AW-1:0] fifo_used;
  logic          RD;
  logic          rdreq;
  logic          pkt_start;
  logic          pkt_done;
  logic [7:0]    word_idx;
  logic [15:0]   pkt_count;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 usbclk = ~usbclk;

  usb_rx_burst_scheduler #(
    .PKT_WORDS  (PKT),
    .FIFO_AW    (AW),
    .GAP_CYCLES (GAP)
  ) dut (
    .usbclk       (usbclk),
    .bus_reset_n  (bus_reset_n),
    .enable       (enable),
    .have_pkt_rdy (have_pkt_rdy),
    .fifo_used    (fifo_used),
    .RD           (RD),
    .rdreq        (rdreq),
    .pkt_start    (pkt_start),
    .pkt_done     (pkt_done),
    .word_idx     (word_idx),
    .pkt_count    (pkt_count),
    .busy         (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Wait (bounded) at negedges for RD; reports how many RD-low cycles passed.
  task automatic wait_rd(input string tag, input int limit, output int waited);
    waited = 0;
    while (RD !== 1'b1 && waited < limit) begin
      waited++;
      @(negedge usbclk);
    end
    check_val({tag, " RD seen"}, 32'(RD), 32'd1);
  endtask

  // Walk one burst starting on its first RD cycle; optionally drop the
  // request inputs at word drop_at. Returns at the first RD-low cycle.
  task automatic run_burst(input string tag, input int drop_at);
    int nw = 0, ns = 0, si = -1, nd = 0, di = -1, oe = 0;
    while (RD === 1'b1 && nw < 300) begin
      if (word_idx !== 8'(nw)) oe++;
      if (rdreq !== 1'b1) oe++;
      if (pkt_start === 1'b1) begin ns++; si = nw; end
      if (pkt_done === 1'b1) begin nd++; di = nw; end
      if (nw == drop_at) begin
        have_pkt_rdy = 1'b0;
        enable       = 1'b0;
      end
      nw++;
      @(negedge usbclk);
    end
    check_val({tag, " words"}, 32'(nw), 32'(PKT));
    check_val({tag, " idx/rdreq errors"}, 32'(oe), 32'd0);
    check_val({tag, " start pulses"}, 32'(ns), 32'd1);
    check_val({tag, " start word"}, 32'(si), 32'd0);
    check_val({tag, " done pulses"}, 32'(nd), 32'd1);
    check_val({tag, " done word"}, 32'(di), 32'(PKT - 1));
    check_val({tag, " rdreq low after"}, 32'(rdreq), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, n, rd_hits, n_bursts;
    bit m_rd, m_start, m_done, qual, space_now, prev_space;
    int m_word, m_last_done;
    logic [15:0] m_count;

    bus_reset_n  = 1'b0;
    enable       = 1'b0;
    have_pkt_rdy = 1'b0;
    fifo_used    = '0;
    repeat (3) @(negedge usbclk);

    // ---- reset values
    check_val("rst RD", 32'(RD), 32'd0);
    check_val("rst rdreq", 32'(rdreq), 32'd0);
    check_val("rst pkt_start", 32'(pkt_start), 32'd0);
    check_val("rst pkt_done", 32'(pkt_done), 32'd0);
    check_val("rst busy", 32'(busy), 32'd0);
    check_val("rst word_idx", 32'(word_idx), 32'd0);
    check_val("rst pkt_count", 32'(pkt_count), 32'd0);
    bus_reset_n = 1'b1;
    @(negedge usbclk);

    // ---- empty FIFO, packet ready: RD one cycle after the qualifying cycle
    enable       = 1'b1;
    have_pkt_rdy = 1'b1;
    fifo_used    = '0;
    @(negedge usbclk);
    check_val("b1 RD latency", 32'(RD), 32'd1);
    check_val("b1 busy", 32'(busy), 32'd1);
    run_burst("b1", -1);
    check_val("b1 pkt_count", 32'(pkt_count), 32'd1);
    wait_rd("b1->b2", 20, g);
    check_val("b1->b2 spacing >= GAP+1", 32'(g + 1 >= GAP + 1), 32'd1);

    // ---- drop flag and enable at word 100: burst still completes
    run_burst("b2 drop@100", 100);
    rd_hits = 0;
    repeat (10) begin
      if (RD === 1'b1) rd_hits++;
      @(negedge usbclk);
    end
    check_val("b2 no new burst", 32'(rd_hits), 32'd0);
    check_val("b2 busy idle", 32'(busy), 32'd0);
    check_val("b2 pkt_count", 32'(pkt_count), 32'd2);

    // ---- FIFO one word too full: wait, then one word less starts a burst
    enable       = 1'b1;
    have_pkt_rdy = 1'b1;
    fifo_used    = 11'(DEPTH - PKT + 1);
    rd_hits = 0;
    repeat (6) begin
      @(negedge usbclk);
      if (RD === 1'b1) rd_hits++;
    end
    check_val("ws no RD", 32'(rd_hits), 32'd0);
    check_val("ws busy", 32'(busy), 32'd1);
    fifo_used = 11'(DEPTH - PKT);
    @(negedge usbclk);
    check_val("ws RD next cycle", 32'(RD), 32'd1);
    check_val("ws pkt_start", 32'(pkt_start), 32'd1);
    run_burst("b3", -1);
    enable = 1'b0;
    check_val("b3 pkt_count", 32'(pkt_count), 32'd3);

    // ---- reset in the middle of a burst
    repeat (4) @(negedge usbclk);
    fifo_used = '0;
    enable    = 1'b1;
    wait_rd("mid-rst burst", 20, g);
    n = 0;
    while (word_idx !== 8'd50 && n < 300) begin
      n++;
      @(negedge usbclk);
    end
    check_val("mid-rst at word 50", 32'(word_idx), 32'd50);
    bus_reset_n = 1'b0;
    #1;
    check_val("mid-rst RD async", 32'(RD), 32'd0);
    check_val("mid-rst rdreq async", 32'(rdreq), 32'd0);
    check_val("mid-rst busy async", 32'(busy), 32'd0);
    @(negedge usbclk);
    check_val("mid-rst no pkt_done", 32'(pkt_done), 32'd0);
    bus_reset_n = 1'b1;
    @(negedge usbclk);
    check_val("post-rst RD", 32'(RD), 32'd1);
    run_burst("post-rst", -1);
    enable = 1'b0;
    check_val("post-rst pkt_count", 32'(pkt_count), 32'd1);

    // ---- counter wrap on pkt_done
    repeat (4) @(negedge usbclk);
    force dut.pkt_count_q = 16'hFFFF;
    @(negedge usbclk);
    release dut.pkt_count_q;
    @(negedge usbclk);
    check_val("wrap preload", 32'(pkt_count), 32'hFFFF);
    enable = 1'b1;
    wait_rd("wrap burst", 20, g);
    run_burst("wrap", -1);
    enable = 1'b0;
    check_val("wrap pkt_count", 32'(pkt_count), 32'd0);

    // ---- randomized run against a packet-level reference model
    bus_reset_n  = 1'b0;
    have_pkt_rdy = 1'b0;
    fifo_used    = '0;
    repeat (2) @(negedge usbclk);
    bus_reset_n  = 1'b1;
    m_rd = 0; m_start = 0; m_done = 0; m_word = 0;
    m_last_done = -1000; m_count = '0; prev_space = 0; n_bursts = 0;
    for (int c = 0; c < 10000; c++) begin
      check_val("rnd RD", 32'(RD), 32'(m_rd));
      check_val("rnd rdreq", 32'(rdreq), 32'(m_rd));
      check_val("rnd pkt_start", 32'(pkt_start), 32'(m_start));
      check_val("rnd pkt_done", 32'(pkt_done), 32'(m_done));
      if (m_rd) check_val("rnd word_idx", 32'(word_idx), 32'(m_word));
      if (!m_done) check_val("rnd pkt_count", 32'(pkt_count), 32'(m_count));
      if (pkt_start === 1'b1) check_val("rnd start needs space", 32'(prev_space), 32'd1);
      if (pkt_done === 1'b1) n_bursts++;

      if ($urandom_range(0, 7) == 0) enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 5) == 0) have_pkt_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0:       fifo_used = 11'($urandom_range(0, DEPTH - 1));
          1:       fifo_used = 11'($urandom_range(DEPTH - PKT - 4, DEPTH - PKT + 4));
          default: fifo_used = 11'($urandom_range(0, 1000));
        endcase
      end

      // Reference: a burst is PKT back-to-back words; a new one may begin the
      // cycle after any qualifying cycle at least GAP cycles after the last
      // word of the previous burst.
      space_now  = (DEPTH - int'(fifo_used)) >= PKT;
      qual       = enable && have_pkt_rdy && space_now;
      prev_space = space_now;
      if (m_rd) begin
        if (m_word == PKT - 1) begin
          m_last_done = c;
          m_rd        = 0;
        end else begin
          m_word++;
        end
      end else if (c >= m_last_done + GAP && qual) begin
        m_rd   = 1;
        m_word = 0;
      end
      m_start = m_rd && (m_word == 0);
      m_done  = m_rd && (m_word == PKT - 1);
      if (m_done) m_count = m_count + 16'd1;
      @(negedge usbclk);
    end
    check_val("rnd bursts observed >= 5", 32'(n_bursts >= 5), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
